// File: rtl/bomb_phase_controller.sv
// rtl/bomb_phase_controller.sv - bomb-defusal phase sequencer with countdown timer and strike counter
module bomb_phase_controller #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TIME_LIMIT_S = 120,
  parameter int PENALTY_S    = 10,
  parameter int MAX_STRIKES  = 3
) (
  input  logic       basys_clock,
  input  logic       reset_n,
  input  logic       arm,
  input  logic       flow_connected,
  input  logic       maze_done,
  input  logic       cut_valid,
  input  logic [2:0] cut_wire,
  input  logic [2:0] target_colour,
  output logic [2:0] phase,
  output logic       flow_en,
  output logic       maze_en,
  output logic [7:0] seconds_left,
  output logic [1:0] strikes,
  output logic       second_tick,
  output logic       defused,
  output logic       exploded
);

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_FLOW     = 3'd1;
  localparam logic [2:0] PH_MAZE     = 3'd2;
  localparam logic [2:0] PH_CUT      = 3'd3;
  localparam logic [2:0] PH_DEFUSED  = 3'd4;
  localparam logic [2:0] PH_EXPLODED = 3'd5;

  localparam int          PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]  T_LIM   = 8'(TIME_LIMIT_S);
  localparam logic [7:0]  PEN     = 8'(PENALTY_S);
  localparam logic [1:0]  MAX_S   = 2'(MAX_STRIKES);

  logic [PW-1:0] prescaler, pre_nx;
  logic [2:0]    phase_nx;
  logic [7:0]    sec_nx, sec_t, sec_pen;
  logic [1:0]    str_nx, strike_inc;
  logic          running, tick, timeout, wrong_cut, good_cut;

  assign running    = (phase == PH_FLOW) || (phase == PH_MAZE) || (phase == PH_CUT);
  assign tick       = running && (prescaler == PRE_MAX);
  assign sec_t      = (tick && seconds_left != 8'd0) ? seconds_left - 8'd1 : seconds_left;
  assign timeout    = tick && (sec_t == 8'd0);
  // Penalty is taken from the already-ticked value so a cut on a tick edge costs both.
  assign sec_pen    = (sec_t > PEN) ? sec_t - PEN : 8'd0;
  assign wrong_cut  = cut_valid && (cut_wire != target_colour);
  assign good_cut   = cut_valid && (cut_wire == target_colour);
  assign strike_inc = strikes + 2'd1;

  always_comb begin
    phase_nx = phase;
    sec_nx   = seconds_left;
    str_nx   = strikes;
    pre_nx   = prescaler;
    if (!arm) begin
      phase_nx = PH_IDLE;
      sec_nx   = T_LIM;
      str_nx   = 2'd0;
      pre_nx   = '0;
    end else begin
      case (phase)
        PH_IDLE: begin
          phase_nx = PH_FLOW;
          sec_nx   = T_LIM;
          str_nx   = 2'd0;
          pre_nx   = '0;
        end
        PH_FLOW, PH_MAZE, PH_CUT: begin
          pre_nx = tick ? '0 : prescaler + 1'b1;
          sec_nx = sec_t;
          if (phase == PH_FLOW) begin
            if (timeout)             phase_nx = PH_EXPLODED;
            else if (flow_connected) phase_nx = PH_MAZE;
          end else if (phase == PH_MAZE) begin
            if (timeout)        phase_nx = PH_EXPLODED;
            else if (maze_done) phase_nx = PH_CUT;
          end else begin
            if (good_cut) begin
              phase_nx = PH_DEFUSED;
            end else if (wrong_cut) begin
              str_nx = strike_inc;
              sec_nx = sec_pen;
              if (strike_inc == MAX_S || sec_pen == 8'd0) phase_nx = PH_EXPLODED;
            end else if (timeout) begin
              phase_nx = PH_EXPLODED;
            end
          end
        end
        PH_DEFUSED, PH_EXPLODED: ;
        default: phase_nx = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= PH_IDLE;
      seconds_left <= T_LIM;
      strikes      <= 2'd0;
      prescaler    <= '0;
      second_tick  <= 1'b0;
      flow_en      <= 1'b0;
      maze_en      <= 1'b0;
      defused      <= 1'b0;
      exploded     <= 1'b0;
    end else begin
      phase        <= phase_nx;
      seconds_left <= sec_nx;
      strikes      <= str_nx;
      prescaler    <= pre_nx;
      second_tick  <= arm && tick;
      flow_en      <= (phase_nx == PH_FLOW);
      maze_en      <= (phase_nx == PH_MAZE);
      defused      <= (phase_nx == PH_DEFUSED);
      exploded     <= (phase_nx == PH_EXPLODED);
    end
  end

endmodule
